// File: rtl/cbc_stream_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cbc_stream_engine_pkg
//  Description : Shared constants and helpers for the CBC stream engine.
//                Holds the FSM state encoding, the block width and the
//                pair-swap substitution used by the 4-bit cipher datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package cbc_stream_engine_pkg;

    localparam int BLK_W = 4;

    // FSM state encoding
    localparam int         ST_W     = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Substitution S: swap the two bits inside each bit pair -> {b2,b3,b0,b1}.
    // S is an involution, so the same function serves encrypt and decrypt.
    function automatic logic [BLK_W-1:0] pair_swap(input logic [BLK_W-1:0] x);
        return {x[2], x[3], x[0], x[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cbc_stream_engine_nibble_core.sv
`default_nettype none
// ============================================================================
//  Module      : cbc_nibble_core
//  Description : Combinational single-block CBC step. Produces the result
//                block and the chaining value for the following block.
//                Encrypt: c = S(p ^ chain ^ key), next chain = c.
//                Decrypt: p = S(c) ^ key ^ chain, next chain = c.
//  Revision    : 1.0 - initial release
// ============================================================================
module cbc_nibble_core
    import cbc_stream_engine_pkg::*;
(
    input  logic             i_mode,
    input  logic [BLK_W-1:0] i_key,
    input  logic [BLK_W-1:0] i_chain,
    input  logic [BLK_W-1:0] i_data,
    output logic [BLK_W-1:0] o_result,
    output logic [BLK_W-1:0] o_next_chain
);

    logic [BLK_W-1:0] w_enc;
    logic [BLK_W-1:0] w_dec;

    assign w_enc = pair_swap(i_data ^ i_chain ^ i_key);
    assign w_dec = pair_swap(i_data) ^ i_key ^ i_chain;

    // Select direction; the chain always follows the ciphertext side
    always_comb begin
        o_result     = i_mode ? w_dec  : w_enc;
        o_next_chain = i_mode ? i_data : w_enc;
    end

endmodule
`default_nettype wire

// File: rtl/cbc_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module      : cbc_stream_engine
//  Description : Sequential CBC front end for the 4-bit block cipher. Accepts
//                a valid/ready block stream, chains each block with the
//                previous ciphertext (IV first) and emits one registered
//                result per cycle with full-throughput backpressure.
//                Optional feature macro: CBC_MAC_EN (adds mac_valid / mac,
//                the final chaining value reported at end of message).
//  Revision    : 1.0 - initial release
// ============================================================================
module cbc_stream_engine
    import cbc_stream_engine_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [BLK_W-1:0] k,
    input  logic [BLK_W-1:0] iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
`ifdef CBC_MAC_EN
    ,
    output logic             mac_valid,
    output logic [BLK_W-1:0] mac
`endif
);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic [BLK_W-1:0] r_chain;
    logic [BLK_W-1:0] r_key;
    logic             r_mode;
    logic             r_out_valid;
    logic [BLK_W-1:0] r_out_data;
    logic             r_out_last;
    logic [CNT_W-1:0] r_blk_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_hs;
    logic             w_start_ok;
    logic [BLK_W-1:0] w_result;
    logic [BLK_W-1:0] w_next_chain;

    assign w_accept   = in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_start_ok = (r_state == ST_IDLE) && start;

    cbc_nibble_core u_core (
        .i_mode       (r_mode),
        .i_key        (r_key),
        .i_chain      (r_chain),
        .i_data       (in_data),
        .o_result     (w_result),
        .o_next_chain (w_next_chain)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: the final block moves to FLUSH, its handshake ends the message
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)                 w_state_nxt = ST_RUN;
            ST_RUN:   if (w_accept && in_last)   w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_out_hs)              w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: a block can enter whenever the output slot is free or draining
    always_comb begin
        w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
        busy       = (r_state != ST_IDLE);
    end

    // Message context: key/mode/IV latched on start, chain advances per accepted block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
            r_key   <= '0;
            r_mode  <= 1'b0;
        end else if (w_start_ok) begin
            r_chain <= iv;
            r_key   <= k;
            r_mode  <= mode;
        end else if (w_accept) begin
            r_chain <= w_next_chain;
        end
    end

    // Output register: load on accept, hold under backpressure, drop after handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_last  <= in_last;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating count of blocks accepted since the last start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_cnt <= '0;
        end else if (w_start_ok) begin
            r_blk_cnt <= '0;
        end else if (w_accept && (r_blk_cnt != {CNT_W{1'b1}})) begin
            r_blk_cnt <= r_blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef CBC_MAC_EN
    logic             r_mac_valid;
    logic [BLK_W-1:0] r_mac;

    // End-of-message MAC: final chaining value, flagged for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mac_valid <= 1'b0;
            r_mac       <= '0;
        end else begin
            r_mac_valid <= 1'b0;
            if ((r_state == ST_FLUSH) && w_out_hs) begin
                r_mac_valid <= 1'b1;
                r_mac       <= r_chain;
            end
        end
    end

    assign mac_valid = r_mac_valid;
    assign mac       = r_mac;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign blk_cnt   = r_blk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cbc_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cbc_stream_engine
//  Description : Self-checking bench for cbc_stream_engine. A CBC reference
//                model (arithmetic pair swap, queue of pending results)
//                tracks every accept and handshake. Honours CBC_MAC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cbc_stream_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [3:0]  k;
    logic [3:0]  iv;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        out_last;
    logic        busy;
    logic [15:0] blk_cnt;
`ifdef CBC_MAC_EN
    logic        mac_valid;
    logic [3:0]  mac;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [3:0] msg[$];
    logic [3:0] got_q[$];
    logic [3:0] last_chain;

    cbc_stream_engine #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .k         (k),
        .iv        (iv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .blk_cnt   (blk_cnt)
`ifdef CBC_MAC_EN
        ,
        .mac_valid (mac_valid),
        .mac       (mac)
`endif
    );

    always #5 clk = ~clk;

    // Reference substitution: move even bits up, odd bits down
    function automatic logic [3:0] ref_s(input logic [3:0] x);
        return ((x & 4'h5) << 1) | ((x & 4'hA) >> 1);
    endfunction

    // Run one message from msg[]; per-cycle checks against the model
    task automatic run_msg(input logic m, input logic [3:0] kk, input logic [3:0] ivv,
                           input int vpct, input int rpct, input int stall_at,
                           input bit stray_start, output int cycles);
        logic [3:0] exp_d[$];
        logic       exp_l[$];
        logic [3:0] ch;
        logic [3:0] res;
        logic [3:0] prev_data;
        bit         running;
        bit         stall_prev;
        int         sent;
        int         n;
        n = msg.size();
        got_q.delete();
        @(negedge clk);
        start = 1'b1; mode = m; k = kk; iv = ivv; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; mode = 1'($urandom); k = 4'($urandom); iv = 4'($urandom);
        cmp_cnt++;
        if (busy !== 1'b1 || blk_cnt !== 16'd0) begin
            err_cnt++;
            $display("FAIL start_state: busy=%b blk_cnt=%0d, required busy=1 blk_cnt=0", busy, blk_cnt);
        end
        ch = ivv; sent = 0; running = 1'b1; stall_prev = 1'b0; prev_data = 4'h0; cycles = 0;
        while ((sent < n || exp_d.size() != 0) && cycles < 1000) begin
            in_valid  = (sent < n) && ($urandom_range(99) < vpct);
            in_data   = in_valid ? msg[sent] : 4'($urandom);
            in_last   = in_valid ? (sent == n - 1) : 1'($urandom);
            out_ready = ($urandom_range(99) < rpct);
            if (cycles >= stall_at && cycles < stall_at + 3) out_ready = 1'b0;
            start     = stray_start && (cycles == 2);
            #1;
            cmp_cnt++;
            if (out_valid !== (exp_d.size() != 0)) begin
                err_cnt++;
                $display("FAIL out_valid: got %b, required %b (cycle %0d)", out_valid, exp_d.size() != 0, cycles);
            end
            cmp_cnt++;
            if (in_ready !== (running && (exp_d.size() == 0 || out_ready))) begin
                err_cnt++;
                $display("FAIL in_ready: got %b, required %b (cycle %0d)", in_ready,
                         running && (exp_d.size() == 0 || out_ready), cycles);
            end
            cmp_cnt++;
            if (blk_cnt !== 16'(sent) || busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL run_status: blk_cnt=%0d busy=%b, required blk_cnt=%0d busy=1", blk_cnt, busy, sent);
            end
            if (stall_prev) begin
                cmp_cnt++;
                if (out_data !== prev_data) begin
                    err_cnt++;
                    $display("FAIL hold_stable: out_data=%h, required %h", out_data, prev_data);
                end
            end
            if (out_valid && out_ready && exp_d.size() != 0) begin
                cmp_cnt++;
                if (out_data !== exp_d[0] || out_last !== exp_l[0]) begin
                    err_cnt++;
                    $display("FAIL out_block: data=%h last=%b, required data=%h last=%b",
                             out_data, out_last, exp_d[0], exp_l[0]);
                end
                got_q.push_back(out_data);
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) begin
                if (m == 1'b0) begin
                    res = ref_s(in_data ^ ch ^ kk);
                    ch  = res;
                end else begin
                    res = ref_s(in_data) ^ kk ^ ch;
                    ch  = in_data;
                end
                exp_d.push_back(res);
                exp_l.push_back(in_last);
                if (in_last) running = 1'b0;
                sent++;
            end
            cycles++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        last_chain = ch;
        cmp_cnt++;
        if (cycles >= 1000) begin
            err_cnt++;
            $display("FAIL timeout: sent=%0d pending=%0d, required all %0d blocks done", sent, exp_d.size(), n);
        end
        #1;
        cmp_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || blk_cnt !== 16'(n)) begin
            err_cnt++;
            $display("FAIL end_state: busy=%b out_valid=%b in_ready=%b blk_cnt=%0d, required 0 0 0 %0d",
                     busy, out_valid, in_ready, blk_cnt, n);
        end
`ifdef CBC_MAC_EN
        cmp_cnt++;
        if (mac_valid !== 1'b1 || mac !== ch) begin
            err_cnt++;
            $display("FAIL mac_pulse: mac_valid=%b mac=%h, required 1 %h", mac_valid, mac, ch);
        end
        @(negedge clk); #1;
        cmp_cnt++;
        if (mac_valid !== 1'b0 || mac !== ch) begin
            err_cnt++;
            $display("FAIL mac_drop: mac_valid=%b mac=%h, required 0 %h", mac_valid, mac, ch);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; k = 4'h0; iv = 4'h0;
        in_valid = 1'b1; in_data = 4'h9; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        cmp_cnt++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_last !== 1'b0 || busy !== 1'b0 ||
            blk_cnt !== 16'd0 || in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_values: ov=%b od=%h ol=%b busy=%b cnt=%0d ir=%b, required all zero",
                     out_valid, out_data, out_last, busy, blk_cnt, in_ready);
        end
`ifdef CBC_MAC_EN
        cmp_cnt++;
        if (mac_valid !== 1'b0 || mac !== 4'h0) begin
            err_cnt++;
            $display("FAIL reset_mac: mac_valid=%b mac=%h, required 0 0", mac_valid, mac);
        end
`endif
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_no_ready: in_ready=%b busy=%b, required 0 0", in_ready, busy);
        end
    endtask

    task automatic test_encrypt_vector();
        int cyc;
        msg = '{4'b0110, 4'b0000};
        run_msg(1'b0, 4'b1010, 4'b0011, 100, 100, 1000, 1'b0, cyc);
        cmp_cnt++;
        if (got_q.size() != 2 || got_q[0] !== 4'b1111 || got_q[1] !== 4'b1010) begin
            err_cnt++;
            $display("FAIL enc_vector: got %0d blocks, required 1111,1010", got_q.size());
        end
        cmp_cnt++;
        if (last_chain !== 4'b1010) begin
            err_cnt++;
            $display("FAIL enc_chain: model chain %b, required 1010", last_chain);
        end
    endtask

    task automatic test_decrypt_vector();
        int cyc;
        msg = '{4'b1111, 4'b1010};
        run_msg(1'b1, 4'b1010, 4'b0011, 100, 60, 1000, 1'b1, cyc);
        cmp_cnt++;
        if (got_q.size() != 2 || got_q[0] !== 4'b0110 || got_q[1] !== 4'b0000) begin
            err_cnt++;
            $display("FAIL dec_vector: got %0d blocks, required 0110,0000", got_q.size());
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        msg.delete();
        for (int i = 0; i < 6; i++) msg.push_back(4'($urandom));
        run_msg(1'b0, 4'($urandom), 4'($urandom), 100, 100, 3, 1'b1, cyc);
        cmp_cnt++;
        if (cyc != 10) begin
            err_cnt++;
            $display("FAIL backpressure_cycles: got %0d, required 10", cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        msg.delete();
        for (int i = 0; i < 8; i++) msg.push_back(4'($urandom));
        run_msg(1'($urandom), 4'($urandom), 4'($urandom), 100, 100, 1000, 1'b0, cyc);
        cmp_cnt++;
        if (cyc != 9) begin
            err_cnt++;
            $display("FAIL stream_cycles: got %0d, required 9", cyc);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        start = 1'b1; mode = 1'b0; k = 4'h5; iv = 4'hC;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 4'h3; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        cmp_cnt++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL pre_reset: out_valid=%b busy=%b, required 1 1", out_valid, busy);
        end
        #2 rst = 1'b1;
        #1;
        cmp_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || blk_cnt !== 16'd0 || out_data !== 4'h0) begin
            err_cnt++;
            $display("FAIL async_reset: ov=%b busy=%b cnt=%0d od=%h, required 0 0 0 0",
                     out_valid, busy, blk_cnt, out_data);
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || blk_cnt !== 16'd0) begin
                err_cnt++;
                $display("FAIL no_start_accept: in_ready=%b out_valid=%b cnt=%0d, required 0 0 0",
                         in_ready, out_valid, blk_cnt);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_random();
        int cyc;
        for (int j = 0; j < 8; j++) begin
            msg.delete();
            for (int i = 0; i < int'($urandom_range(10, 1)); i++) msg.push_back(4'($urandom));
            run_msg(1'($urandom), 4'($urandom), 4'($urandom), 70, 65, 1000, 1'($urandom), cyc);
        end
    endtask

    initial begin
        test_reset();
        test_encrypt_vector();
        test_decrypt_vector();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_encrypt_vector();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
